// File: rtl/apb_irqfilter.sv
// Input conditioning for external interrupt pins, upstream of the edge-interrupt APB block.
//
// Each asynchronous pin goes through a 2-flop synchroniser, then a per-channel polarity
// inversion, then a debounce filter. The filtered level only moves after the conditioned input
// has disagreed with it on DEB+1 consecutive enabled edges.
//
// Ports:
//   pclk, reset      clock and synchronous active-high reset
//   enable           clock-gating qualifier; all state holds while low
//   paddr..pwdata    APB slave inputs (paddr[1:0] ignored)
//   prdata           registered read data, 0 on enabled cycles without a read
//   pready, pslverr  tied 1 / 0
//   irq_raw          asynchronous interrupt pins
//   irq_level        filtered, pclk-synchronous, active-high levels
//
// Register map (word addresses):
//   0x0 POL  RW  [NUM_IRQ-1:0]  1 = invert channel
//   0x4 DEB  RW  [CNT_W-1:0]    debounce length N
//   0x8 STAT RO  {conditioned inputs at [NUM_IRQ+15:16], irq_level at [NUM_IRQ-1:0]}

module apb_irqfilter #(
    parameter int unsigned NUM_IRQ = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               enable,
    input  logic [3:0]         paddr,
    input  logic               pwrite,
    input  logic               psel,
    input  logic               penable,
    input  logic [31:0]        pwdata,
    output logic [31:0]        prdata,
    output logic               pready,
    output logic               pslverr,
    input  logic [NUM_IRQ-1:0] irq_raw,
    output logic [NUM_IRQ-1:0] irq_level
);

    logic [NUM_IRQ-1:0] sync1_q, sync2_q;
    logic [NUM_IRQ-1:0] pol_q;
    logic [CNT_W-1:0]   deb_q;
    logic [NUM_IRQ-1:0] level_q, level_d;
    logic [CNT_W-1:0]   cnt_q [NUM_IRQ];
    logic [CNT_W-1:0]   cnt_d [NUM_IRQ];
    logic [31:0]        prdata_q;
    logic [31:0]        rdata;
    logic [NUM_IRQ-1:0] x;

    logic apb_write, apb_read;
    logic unused_apb;

    assign apb_write = psel & penable & pwrite;
    // Read data is captured in the setup phase so it is valid during the access phase.
    assign apb_read  = psel & ~pwrite;

    assign pready    = 1'b1;
    assign pslverr   = 1'b0;
    assign prdata    = prdata_q;
    assign irq_level = level_q;

    assign unused_apb = ^{paddr[1:0], pwdata};

    // Polarity applies combinationally so a POL write is seen by the filter on the next edge.
    assign x = sync2_q ^ pol_q;

    // Debounce: the counter tracks how long x has disagreed with the output. Using >= lets a
    // DEB write below an in-flight count complete on the next edge instead of wrapping.
    always_comb begin
        level_d = level_q;
        for (int b = 0; b < NUM_IRQ; b++) begin
            cnt_d[b] = cnt_q[b];
            if (x[b] == level_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] >= deb_q) begin
                level_d[b] = x[b];
                cnt_d[b]   = '0;
            end else begin
                cnt_d[b] = cnt_q[b] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (paddr[3:2])
            2'd0: rdata[NUM_IRQ-1:0] = pol_q;
            2'd1: rdata[CNT_W-1:0]   = deb_q;
            2'd2: begin
                rdata[NUM_IRQ+15:16] = x;
                rdata[NUM_IRQ-1:0]   = level_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            pol_q    <= '0;
            deb_q    <= '0;
            level_q  <= '0;
            prdata_q <= '0;
            for (int b = 0; b < NUM_IRQ; b++) begin
                cnt_q[b] <= '0;
            end
        end else if (enable) begin
            sync1_q <= irq_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            for (int b = 0; b < NUM_IRQ; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
            if (apb_write && paddr[3:2] == 2'd0) begin
                pol_q <= pwdata[NUM_IRQ-1:0];
            end
            if (apb_write && paddr[3:2] == 2'd1) begin
                deb_q <= pwdata[CNT_W-1:0];
            end
            // Zero when idle so several slaves' read buses can be ORed.
            prdata_q <= apb_read ? rdata : '0;
        end
    end

endmodule

// File: tb/tb_apb_irqfilter.sv
module tb_apb_irqfilter;

    logic        pclk;
    logic        reset;
    logic        enable;
    logic [3:0]  paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [3:0]  irq_raw;
    logic [3:0]  irq_level;

    int n_checks = 0;
    int n_fails  = 0;

    apb_irqfilter #(
        .NUM_IRQ (4),
        .CNT_W   (8)
    ) dut (
        .pclk      (pclk),
        .reset     (reset),
        .enable    (enable),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .psel      (psel),
        .penable   (penable),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .irq_raw   (irq_raw),
        .irq_level (irq_level)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Reference model: a channel's output takes the conditioned input once that input has been
    // seen disagreeing with the output on more than DEB consecutive enabled edges.
    logic [3:0]  m_s1     = '0;
    logic [3:0]  m_s2     = '0;
    logic [3:0]  m_pol    = '0;
    logic [7:0]  m_deb    = '0;
    logic [3:0]  m_level  = '0;
    logic [31:0] m_prdata = '0;
    int          m_seen [4];

    always @(posedge pclk) begin : model
        logic [3:0]  mx;
        logic [3:0]  lvl;
        logic [31:0] rd;
        int          seen;
        if (reset) begin
            m_s1     <= '0;
            m_s2     <= '0;
            m_pol    <= '0;
            m_deb    <= '0;
            m_level  <= '0;
            m_prdata <= '0;
            for (int b = 0; b < 4; b++) m_seen[b] <= 0;
        end else if (enable) begin
            mx  = m_s2 ^ m_pol;
            lvl = m_level;
            for (int b = 0; b < 4; b++) begin
                if (mx[b] != m_level[b]) begin
                    seen = m_seen[b] + 1;
                    if (seen > int'(m_deb)) begin
                        lvl[b] = mx[b];
                        seen   = 0;
                    end
                end else begin
                    seen = 0;
                end
                m_seen[b] <= seen;
            end
            case (paddr[3:2])
                2'd0:    rd = {28'd0, m_pol};
                2'd1:    rd = {24'd0, m_deb};
                2'd2:    rd = {12'd0, mx, 12'd0, m_level};
                default: rd = 32'd0;
            endcase
            m_prdata <= (psel && !pwrite) ? rd : 32'd0;
            if (psel && penable && pwrite && paddr[3:2] == 2'd0) m_pol <= pwdata[3:0];
            if (psel && penable && pwrite && paddr[3:2] == 2'd1) m_deb <= pwdata[7:0];
            m_s2    <= m_s1;
            m_s1    <= irq_raw;
            m_level <= lvl;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
        psel    = 1'b1;
        pwrite  = 1'b1;
        penable = 1'b0;
        paddr   = addr;
        pwdata  = data;
        tick();
        penable = 1'b1;
        tick();
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] addr, output logic [31:0] data);
        psel    = 1'b1;
        pwrite  = 1'b0;
        penable = 1'b0;
        paddr   = addr;
        tick();
        data    = prdata;
        penable = 1'b1;
        tick();
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  addr;
        bit          wr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } reg_vec_t;

    reg_vec_t vec [14];

    initial begin : stim
        logic [31:0] rd;
        logic [15:0] mask;
        logic [3:0]  flip;
        logic [1:0]  a;

        vec[0]  = '{4'h0, 1'b0, 32'h0,         32'h0,         "rst_pol"};
        vec[1]  = '{4'h4, 1'b0, 32'h0,         32'h0,         "rst_deb"};
        vec[2]  = '{4'h8, 1'b0, 32'h0,         32'h0,         "rst_stat"};
        vec[3]  = '{4'h4, 1'b1, 32'h0000_01FF, 32'h0,         ""};
        vec[4]  = '{4'h4, 1'b0, 32'h0,         32'h0000_00FF, "deb_rw"};
        vec[5]  = '{4'h0, 1'b1, 32'hFFFF_FFFF, 32'h0,         ""};
        vec[6]  = '{4'h0, 1'b0, 32'h0,         32'h0000_000F, "pol_rw"};
        vec[7]  = '{4'h8, 1'b1, 32'hFFFF_FFFF, 32'h0,         ""};
        vec[8]  = '{4'h8, 1'b0, 32'h0,         32'h000F_0000, "stat_ro"};
        vec[9]  = '{4'hC, 1'b1, 32'h0000_1234, 32'h0,         ""};
        vec[10] = '{4'hC, 1'b0, 32'h0,         32'h0,         "unmapped"};
        vec[11] = '{4'h0, 1'b1, 32'h0,         32'h0,         ""};
        vec[12] = '{4'h4, 1'b1, 32'h0,         32'h0,         ""};
        vec[13] = '{4'h4, 1'b0, 32'h0,         32'h0,         "deb_clr"};

        reset   = 1'b1;
        enable  = 1'b1;
        paddr   = '0;
        pwrite  = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwdata  = '0;
        irq_raw = '0;
        tick(2);
        reset = 1'b0;
        tick();

        check("rst_level", {28'd0, irq_level}, 32'h0);
        check("rst_prdata", prdata, 32'h0);
        check("pready", {31'd0, pready}, 32'h1);
        check("pslverr", {31'd0, pslverr}, 32'h0);

        // Register access table
        for (int i = 0; i < 14; i++) begin
            if (vec[i].wr) begin
                apb_write(vec[i].addr, vec[i].wdata);
            end else begin
                apb_read(vec[i].addr, rd);
                check(vec[i].name, rd, vec[i].exp);
            end
        end
        check("table_no_flip", {28'd0, irq_level}, 32'h0);

        // Latency with DEB=3: rise on the 6th edge counting the first sampling edge
        apb_write(4'h4, 32'd3);
        irq_raw[0] = 1'b1;
        mask = '0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            mask[t-1] = irq_level[0];
        end
        check("latency_deb3", {16'd0, mask}, 32'h0000_00E0);
        apb_read(4'h8, rd);
        check("stat_ch0", rd, 32'h0001_0001);

        // Glitch rejection on channel 1 with DEB=3
        for (int p = 0; p < 3; p++) begin
            int len;
            len  = (p == 0) ? 2 : (p == 1) ? 3 : 5;
            mask = '0;
            irq_raw[1] = 1'b1;
            for (int t = 1; t <= 16; t++) begin
                tick();
                mask[t-1] = irq_level[1];
                if (t == len) irq_raw[1] = 1'b0;
            end
            check($sformatf("pulse_len%0d", len), {16'd0, mask},
                  (len == 5) ? 32'h0000_03E0 : 32'h0);
        end

        // POL write with all pins high: channels 0 and 2 drop after three edges, 1 and 3 stay
        apb_write(4'h4, 32'd2);
        irq_raw = 4'hF;
        tick(8);
        check("pol_pre", {28'd0, irq_level}, 32'hF);
        apb_write(4'h0, 32'h5);
        mask[15:12] = irq_level;
        tick();
        mask[11:8] = irq_level;
        tick();
        mask[7:4] = irq_level;
        tick();
        mask[3:0] = irq_level;
        check("pol_switch", {16'd0, mask}, 32'h0000_FFFA);
        apb_write(4'h0, 32'h0);
        tick(6);
        check("pol_restore", {28'd0, irq_level}, 32'hF);

        // Shrinking DEB below an in-flight count fires on the next edge
        irq_raw = 4'h0;
        tick(8);
        check("deb_setup", {28'd0, irq_level}, 32'h0);
        apb_write(4'h4, 32'd200);
        irq_raw[2] = 1'b1;
        tick(52);
        check("deb_long_hold", {28'd0, irq_level}, 32'h0);
        apb_write(4'h4, 32'd10);
        check("deb_shrink_hold", {31'd0, irq_level[2]}, 32'h0);
        tick();
        check("deb_shrink_fire", {31'd0, irq_level[2]}, 32'h1);

        // enable low for 4 edges stretches the latency by exactly 4
        apb_write(4'h4, 32'd3);
        tick(6);
        irq_raw[3] = 1'b1;
        mask = '0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            mask[t-1] = irq_level[3];
            if (t == 3) enable = 1'b0;
            if (t == 7) enable = 1'b1;
        end
        check("enable_freeze", {16'd0, mask}, 32'h0000_0E00);

        // Reset mid-count: no pulse, everything cleared
        irq_raw[1] = 1'b1;
        mask = '0;
        for (int t = 1; t <= 4; t++) begin
            tick();
            mask[t-1] = irq_level[1];
        end
        reset = 1'b1;
        tick();
        check("rst_mid_clear", {28'd0, irq_level}, 32'h0);
        mask[4] = irq_level[1];
        tick();
        reset = 1'b0;
        mask[5] = irq_level[1];
        tick();
        mask[6] = |irq_level;
        check("rst_mid_no_pulse", {16'd0, mask}, 32'h0);
        check("model_directed", {28'd0, irq_level}, {28'd0, m_level});

        // Randomised traffic against the reference model
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 7) == 0);
            irq_raw = irq_raw ^ flip;
            enable  = ($urandom_range(0, 9) != 0);
            reset   = ($urandom_range(0, 299) == 0);
            psel    = ($urandom_range(0, 1) == 1);
            penable = ($urandom_range(0, 1) == 1);
            pwrite  = ($urandom_range(0, 1) == 1);
            a       = 2'($urandom_range(0, 3));
            paddr   = {a, 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) pwdata = $urandom;
            else pwdata = $urandom_range(0, 5);
            tick();
            check("rand_level", {28'd0, irq_level}, {28'd0, m_level});
            check("rand_prdata", prdata, m_prdata);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
